// File: rtl/op_shift_pkg.sv
// Shared types for op_shift_unit: opcode and FSM state enums plus an opcode classifier.
package op_shift_pkg;

  typedef enum logic [2:0] {
    OP_PASS = 3'b000,
    OP_INV  = 3'b001,
    OP_SLL  = 3'b010,
    OP_SRL  = 3'b011,
    OP_SRA  = 3'b100,
    OP_ROL  = 3'b101,
    OP_ROR  = 3'b110,
    OP_REV  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // Ops that finish in one cycle and ignore the shift amount.
  function automatic logic is_single(input op_e op);
    return (op == OP_PASS) || (op == OP_INV) || (op == OP_REV);
  endfunction

endpackage

// File: rtl/op_shift_step.sv
// Combinational datapath for op_shift_unit: one-bit shift/rotate step and single-cycle results.
// The shifted-out bit output exists only when OP_SHIFT_FLAGS_EN is defined.
module op_shift_step
  import op_shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] acc,
  input  op_e              op,
  output logic [WIDTH-1:0] step_res,
  output logic [WIDTH-1:0] single_res
`ifdef OP_SHIFT_FLAGS_EN
  ,
  output logic             shout
`endif
);

  logic shout_c;

  // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    step_res   = acc;
    single_res = acc;
    shout_c    = 1'b0;
    case (op)
      OP_SLL: begin
        step_res = {acc[WIDTH-2:0], 1'b0};
        shout_c  = acc[WIDTH-1];
      end
      OP_SRL: begin
        step_res = {1'b0, acc[WIDTH-1:1]};
        shout_c  = acc[0];
      end
      OP_SRA: begin
        step_res = {acc[WIDTH-1], acc[WIDTH-1:1]};
        shout_c  = acc[0];
      end
      OP_ROL:  step_res = {acc[WIDTH-2:0], acc[WIDTH-1]};
      OP_ROR:  step_res = {acc[0], acc[WIDTH-1:1]};
      OP_INV:  single_res = ~acc;
      OP_REV: begin
        for (int i = 0; i < WIDTH; i++) single_res[i] = acc[WIDTH-1-i];
      end
      default: ;
    endcase
  end

`ifdef OP_SHIFT_FLAGS_EN
  assign shout = shout_c;
`endif

endmodule

// File: rtl/op_shift_unit.sv
// Handshaked opcode unit: single-cycle pass/invert/reverse, iterative 1-bit-per-cycle shifts and rotates.
// Optional zero/cout flag outputs are built when OP_SHIFT_FLAGS_EN is defined.
module op_shift_unit
  import op_shift_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in,
  input  logic [2:0]       op,
  input  logic [SHW-1:0]   amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             busy
`ifdef OP_SHIFT_FLAGS_EN
  ,
  output logic             zero,
  output logic             cout
`endif
);

  state_e           state_q, state_d;
  op_e              op_q;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q;
  logic             load_out;

  // In IDLE the datapath sees the incoming operand; afterwards it works on the accumulator.
  logic [WIDTH-1:0] step_in;
  op_e              step_op;
  logic [WIDTH-1:0] step_res, single_res;

  assign step_in = (state_q == IDLE) ? in : acc_q;
  assign step_op = (state_q == IDLE) ? op_e'(op) : op_q;

`ifdef OP_SHIFT_FLAGS_EN
  logic shout, cout_d, zero_q, cout_q;
`endif

  op_shift_step #(.WIDTH(WIDTH)) u_step (
    .acc        (step_in),
    .op         (step_op),
    .step_res   (step_res),
    .single_res (single_res)
`ifdef OP_SHIFT_FLAGS_EN
    ,
    .shout      (shout)
`endif
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    load_out = 1'b0;
`ifdef OP_SHIFT_FLAGS_EN
    cout_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // single_res defaults to pass, which covers a zero-amount shift.
          if (is_single(op_e'(op)) || (amt == '0)) begin
            acc_d    = single_res;
            state_d  = DONE;
            load_out = 1'b1;
          end else begin
            acc_d   = in;
            cnt_d   = amt;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        acc_d = step_res;
        cnt_d = cnt_q - SHW'(1);
`ifdef OP_SHIFT_FLAGS_EN
        cout_d = shout;
`endif
        if (cnt_q == SHW'(1)) begin
          state_d  = DONE;
          load_out = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_PASS;
      acc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      if ((state_q == IDLE) && in_valid) op_q <= op_e'(op);
      if (load_out) out_q <= acc_d;
    end
  end

`ifdef OP_SHIFT_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      cout_q <= 1'b0;
    end else if (load_out) begin
      zero_q <= (acc_d == '0);
      cout_q <= cout_d;
    end
  end

  assign zero = zero_q;
  assign cout = cout_q;
`endif

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign out       = out_q;

endmodule

// File: doc/op_shift_unit.md
# op_shift_unit

Parametrised, handshaked successor to the team's 8-bit opcode-selected operation block. Accepts one `WIDTH`-bit operand with a 3-bit opcode and a shift amount, and returns the result over a valid/ready interface. Shift and rotate operations run iteratively, one bit position per cycle. Sits between an upstream operand producer and a downstream consumer in the project datapath.

## Interface
- `WIDTH`, default 8: operand/result width; must be a power of two and at least 4.
- `SHW`, default `$clog2(WIDTH)`: shift-amount width; derived, not overridden.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `in_valid`  in  1: operand valid.
- `in_ready`  out  1: block can accept; equals state==IDLE.
- `in`  in  WIDTH: operand.
- `op`  in  3: opcode.
- `amt`  in  SHW: shift/rotate amount.
- `out_valid`  out  1: result valid.
- `out_ready`  in  1: consumer ready.
- `out`  out  WIDTH: result.
- `busy`  out  1: state!=IDLE.
- `zero`, `cout`  out  1 each: present only with `OP_SHIFT_FLAGS_EN`.

## Operation
Opcode map:
- 000 pass
- 001 bitwise invert
- 010 SLL
- 011 SRL
- 100 SRA (msb fill)
- 101 ROL
- 110 ROR
- 111 bit-reverse

`amt` is ignored for 000, 001 and 111.

FSM states: IDLE, RUN, DONE.
- **IDLE:** `in_ready`=1. On `in_valid`, capture `in`/`op`/`amt`.
  - Single-step op (000/001/111), or shift op with `amt`=0: acc ← f(in), go to DONE. For `amt`=0, f is pass.
  - Otherwise: acc ← in, cnt ← amt, go to RUN.
- **RUN:** each cycle apply one 1-bit step to acc and decrement cnt. The step that brings cnt to 0 moves to DONE. `in_valid` is ignored (`in_ready`=0).
- **DONE:** `out_valid`=1, `out`=acc, held stable until `out_ready`. On `out_ready`, go to IDLE. There is no same-cycle re-accept; the next operand is accepted one cycle later.
- Width rules: all shifts are modular in `WIDTH`; the largest `amt` is `WIDTH`-1. Bits shifted out are lost; SLL/SRL fill with 0.
- Reset mid-operation: the transaction is aborted and discarded. No partial result is ever presented.

## Timing
- Reset values: state=IDLE, acc=0, cnt=0, `out`=0, `out_valid`=0, `busy`=0, `in_ready`=1, `zero`=0, `cout`=0.
- Acceptance edge = edge 0 (`in_valid && in_ready` sampled).
- `out_valid` is first sampled high:
  - at edge 1 for single-step ops and for `amt`=0;
  - at edge `amt`+1 for shift/rotate ops with `amt`>0.
- `in_ready` is low from after edge 0 until the edge following the `out_valid && out_ready` handshake.
- `out` changes only at the edge entering DONE or on reset.
- Throughput: one operation per (latency + 1) cycles, with `out_ready` tied high.

## Configuration
- `OP_SHIFT_FLAGS_EN` defined:
  - `zero` = (acc==0), valid with `out_valid`.
  - `cout` = last bit shifted out by SLL/SRL/SRA, else 0.
  - Both are registered alongside acc and held through DONE.
- Not defined: `zero`/`cout` ports and the associated logic are absent.

## Structure
- Package `op_shift_pkg`: `op_e` opcode enum (8 values above), `state_e` {IDLE, RUN, DONE}.
- Sub-module `op_shift_step`: combinational. Given acc and op, it returns the one-bit shift/rotate step, the single-step results (invert, reverse, pass), and the shifted-out bit. The top level holds the FSM, acc, cnt and the handshake.

## Test plan
All scenarios use WIDTH=8.
- Invert: in=10010110, op=001 → out=01101001; `out_valid` sampled high at edge 1; `in_ready` low while DONE.
- SLL: in=00000111, op=010, amt=3 → out=00111000 at edge 4; `busy`=1 edges 1–4; flags build gives `cout`=0, `zero`=0.
- SRA: in=10000100, op=100, amt=2 → out=11100001 at edge 3. SRL amt=0 on the same input → out=10000100 at edge 1.
- ROR with backpressure: in=00000001, op=110, amt=7 → out=00000010 at edge 8. Hold `out_ready`=0 for 5 cycles and drive `in_valid` with a new operand: `out` stays stable and the new operand is not accepted until after the handshake.
- Reset mid-RUN: start ROL amt=5, drop `rst_n` at edge 2 → `out_valid`=0 and `out`=0 immediately (async). After release, `in_ready`=1; bit-reverse of 11000001 → 10000011 at edge 1.
